data_mem_port: RTL and testbench

Multi-cycle load/store responder on the data-memory side of the CPU. It consumes the memory controls the instruction decoder produces: read/write, `sign`, and `length` with 00 = byte, 01 = half, 10 = word. It runs the access against a single-port synchronous word RAM, stalls the pipeline until the access completes, and returns aligned, extended load data. Sub-word stores are done as read-modify-write; misaligned accesses are trapped without touching RAM.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/load_align.sv | 23 ++
 rtl/data_mem_port.sv | 116 +++++++++++
 tb/tb_data_mem_port.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state and request record for the data-memory port.
package mem_pkg;
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  // Lane geometry inside a 32-bit RAM word
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE, DONE} state_t;

  // Access attributes latched in IDLE and replayed for the rest of the transaction
  typedef struct packed {
    logic       wr;
    logic       sgn;
    logic [1:0] len;
    logic [1:0] off;
  } req_t;

  // Encoding 11 behaves as a word access
  function automatic logic is_word(input logic [1:0] len);
    return len[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] len, input logic [1:0] off);
    return ((len == LEN_H) && off[0]) || (is_word(len) && (off != 2'b00));
  endfunction
endpackage

// File: rtl/load_align.sv
// Combinational lane select plus sign/zero extension of a loaded RAM word.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [1:0]        len,
  input  logic              sign,
  output logic [DATA_W-1:0] data
);
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;

  always_comb begin
    b    = word[{off, 3'b000} +: BYTE_W];
    h    = word[{off[1], 4'b0000} +: HALF_W];
    data = word;
    if (len == LEN_B)      data = {{(DATA_W-BYTE_W){sign & b[BYTE_W-1]}}, b};
    else if (len == LEN_H) data = {{(DATA_W-HALF_W){sign & h[HALF_W-1]}}, h};
  end
endmodule

// File: rtl/data_mem_port.sv
// Multi-cycle load/store responder: stalls the pipeline, aligns loads,
// read-modify-writes sub-word stores and traps misaligned accesses.
module data_mem_port
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              sign,
  input  logic [1:0]        length,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_t            state, nstate;
  req_t              r_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              mis_q;
  logic              req, mis_in;
  logic [DATA_W-1:0] ld_data, merged;
  logic              unused_addr;

  assign req         = mem_read | mem_write;
  assign mis_in      = misaligned(length, addr[1:0]);
  assign unused_addr = ^addr[DATA_W-1:ADDR_W+2];

  load_align #(.DATA_W(DATA_W)) u_align (
    .word (ram_rdata),
    .off  (r_q.off),
    .len  (r_q.len),
    .sign (r_q.sgn),
    .data (ld_data)
  );

  // Old word from the IDLE read, with the addressed lane overwritten
  always_comb begin
    merged = ram_rdata;
    if (r_q.len == LEN_B) merged[{r_q.off, 3'b000} +: BYTE_W]    = wd_q[BYTE_W-1:0];
    else                  merged[{r_q.off[1], 4'b0000} +: HALF_W] = wd_q[HALF_W-1:0];
  end

  always_comb begin
    nstate    = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = wa_q;
    ram_wdata = wd_q;
    case (state)
      IDLE: begin
        ram_addr  = addr[ADDR_W+1:2];
        ram_wdata = wdata;
        if (req) begin
          if (mis_in) begin
            nstate = DONE;
          end else begin
            ram_en = 1'b1;
            ram_we = mem_write & is_word(length);
            nstate = (mem_write & is_word(length)) ? DONE : RD_WAIT;
          end
        end
      end
      RD_WAIT: nstate = r_q.wr ? MERGE : DONE;
      MERGE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = merged;
        nstate    = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
    // RAM strobes must be dead the instant reset asserts
    if (!rst_n) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r_q   <= '0;
      wa_q  <= '0;
      wd_q  <= '0;
      mis_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && req) begin
        r_q   <= '{wr: mem_write, sgn: sign, len: length, off: addr[1:0]};
        wa_q  <= addr[ADDR_W+1:2];
        wd_q  <= wdata;
        mis_q <= mis_in;
        if (mis_in) rdata <= '0;
      end
      if (state == RD_WAIT && !r_q.wr) rdata <= ld_data;
    end
  end

  assign done     = (state == DONE);
  assign misalign = done & mis_q;
  assign stall    = rst_n & req & (state != DONE);
endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: RAM model, reference memory model and
// a per-cycle compare of stall/done/misalign/rdata/RAM address.
module tb_data_mem_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, sign = 1'b0;
  logic [1:0]  length = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, done, misalign, ram_en, ram_we;
  logic [31:0] rdata, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [13:0] ram_addr;

  data_mem_port #(.DATA_W(32), .ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .sign(sign), .length(length), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM; read output holds when not re-read
  logic [31:0] ram [0:16383];
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end

  int n_vec = 0, n_bad = 0;
  int n_en = 0, n_we = 0;
  bit chk_on = 1'b0;
  logic        exp_stall = 1'b0, exp_done = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [13:0] exp_waddr = '0;
  logic [31:0] mdl [0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_on) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("done", 32'(done), 32'(exp_done));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      chk("rdata", rdata, exp_rdata);
      if (ram_en) begin
        n_en++;
        chk("ram_addr", 32'(ram_addr), 32'(exp_waddr));
      end
      if (ram_we) n_we++;
    end

  function automatic logic [31:0] mload(input logic [31:0] w, input logic [1:0] len,
                                        input bit sg, input logic [31:0] a);
    logic [31:0] v;
    if (len == 2'b00) begin
      v = (w >> (int'(a[1:0]) * 8)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (len == 2'b01) begin
      v = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  task automatic preload(input int wi, input logic [31:0] v);
    ram[wi] = v;
    mdl[wi] = v;
  endtask

  // One access, called just after a rising edge; returns one edge after DONE
  task automatic xact(input bit wr, input bit both, input bit sg, input logic [1:0] len,
                      input logic [31:0] a, input logic [31:0] wd);
    bit mis, word;
    int lat, en_exp;
    logic [31:0] nr, mask, w;
    word = len[1];
    mis  = (len == 2'b01 && a[0]) || (word && a[1:0] != 2'b00);
    lat  = mis ? 2 : (wr ? (word ? 2 : 4) : 3);
    en_exp = mis ? 0 : ((wr && !word) ? 2 : 1);
    w  = mdl[a[5:2]];
    nr = mis ? 32'h0 : (wr ? exp_rdata : mload(w, len, sg, a));
    mem_read = !wr || both; mem_write = wr; sign = sg; length = len; addr = a; wdata = wd;
    exp_waddr = a[15:2];
    n_en = 0; n_we = 0;
    for (int k = 0; k < lat; k++) begin
      exp_stall = (k < lat - 1);
      exp_done  = (k == lat - 1);
      exp_mis   = exp_done & mis;
      if (k == lat - 1) exp_rdata = nr;
      @(posedge clk); #1;
    end
    if (wr && !mis) begin
      mask = word ? 32'hFFFF_FFFF : (len == 2'b00 ? 32'hFF : 32'hFFFF);
      mask = mask << (word ? 0 : int'(a[1:0]) * 8);
      mdl[a[5:2]] = (w & ~mask) | ((wd << (word ? 0 : int'(a[1:0]) * 8)) & mask);
    end
    chk("we_pulses", n_we, (wr && !mis) ? 1 : 0);
    chk("en_pulses", n_en, en_exp);
    if (wr && !mis) chk("ram_word", ram[a[15:2]], mdl[a[5:2]]);
    mem_read = 1'b0; mem_write = 1'b0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
  endtask

  initial begin
    preload(0, 32'h80FF_7F01);
    preload(1, 32'h1122_3344);
    preload(2, 32'h0);
    preload(4, 32'h5566_7788);
    // Request held during reset must not reach the RAM or stall
    mem_read = 1'b1; length = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    mem_read = 1'b0;
    rst_n = 1'b1;
    chk_on = 1'b1;

    xact(0, 0, 1, 2'b00, 32'h3, 0);
    chk("lit_sbyte", rdata, 32'hFFFF_FF80);
    xact(0, 0, 0, 2'b01, 32'h2, 0);
    chk("lit_uhalf", rdata, 32'h0000_80FF);
    xact(0, 0, 1, 2'b01, 32'h2, 0);
    xact(0, 0, 0, 2'b00, 32'h0, 0);
    chk("lit_ubyte", rdata, 32'h0000_0001);
    xact(0, 0, 1, 2'b11, 32'h0, 0);
    chk("lit_len11", rdata, 32'h80FF_7F01);

    // Word store (read+write both asserted -> write wins), then byte RMW
    xact(1, 1, 0, 2'b10, 32'h0, 32'h1122_3344);
    xact(1, 0, 0, 2'b00, 32'h1, 32'hFFFF_FFAB);
    chk("lit_bstore", ram[0], 32'h1122_AB44);
    xact(1, 0, 0, 2'b01, 32'h6, 32'hFFFF_CAFE);
    xact(0, 0, 1, 2'b00, 32'h7, 0);

    xact(0, 0, 0, 2'b10, 32'h6, 0);
    chk("lit_mis_rdata", rdata, 32'h0);
    xact(0, 0, 0, 2'b00, 32'h1, 0);
    xact(1, 0, 0, 2'b01, 32'h3, 32'h0000_5555);
    chk("lit_mis_noram", ram[0], 32'h1122_AB44);

    xact(1, 0, 0, 2'b10, 32'h8, 32'hDEAD_BEEF);
    xact(0, 0, 0, 2'b10, 32'h8, 0);
    chk("lit_b2b", rdata, 32'hDEAD_BEEF);

    // Half store interrupted by reset while in RD_WAIT
    mem_write = 1'b1; length = 2'b01; addr = 32'h12; wdata = 32'h1234; sign = 1'b0;
    exp_waddr = 14'd4; exp_stall = 1'b1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    exp_stall = 1'b0; exp_rdata = '0;
    #1;
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_ram_en", 32'(ram_en), 0);
    chk("midrst_ram_we", 32'(ram_we), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rdata", rdata, 0);
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ram", ram[4], 32'h5566_7788);
    rst_n = 1'b1;
    xact(1, 0, 0, 2'b01, 32'h12, 32'h1234);
    xact(0, 0, 0, 2'b10, 32'h10, 0);
    chk("lit_post_rst", rdata, 32'h1234_7788);

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
